// File: rtl/cmp_bist_pkg.sv
// Shared types and constants for the comparator BIST engine.
package cmp_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned FLAG_LT = 2;
    localparam int unsigned FLAG_GT = 1;
    localparam int unsigned FLAG_EQ = 0;

endpackage

// File: rtl/cmp_bist_golden.sv
// Combinational reference comparator; flags packed as {lt, gt, eq}.
module cmp_bist_golden
    import cmp_bist_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [2:0]       flags_o
);

    always_comb begin
        flags_o          = '0;
        flags_o[FLAG_LT] = (a_i < b_i);
        flags_o[FLAG_GT] = (a_i > b_i);
        flags_o[FLAG_EQ] = (a_i == b_i);
    end

endmodule

// File: rtl/comparator_bist.sv
// Exhaustive self-test sweep for a WIDTH-bit magnitude comparator with saturating error count.
// Define CMP_BIST_FIRST_FAIL_EN to add capture of the first mismatching vector.
module comparator_bist
    import cmp_bist_pkg::*;
#(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    input  logic                 dut_lt,
    input  logic                 dut_gt,
    input  logic                 dut_eq,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef CMP_BIST_FIRST_FAIL_EN
    ,
    output logic                 fail_valid,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic [2:0]           fail_flags
`endif
);

    localparam int unsigned VW = 2 * WIDTH;

    state_e               state_q, state_d;
    logic [VW-1:0]        vec_q, vec_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [2:0]           exp_flags;
    logic [2:0]           obs_flags;
    logic                 mismatch;
    logic                 last_vec;
    logic                 start_sweep;

    cmp_bist_golden #(.WIDTH(WIDTH)) u_golden (
        .a_i     (vec_q[VW-1:WIDTH]),
        .b_i     (vec_q[WIDTH-1:0]),
        .flags_o (exp_flags)
    );

    always_comb begin
        obs_flags          = '0;
        obs_flags[FLAG_LT] = dut_lt;
        obs_flags[FLAG_GT] = dut_gt;
        obs_flags[FLAG_EQ] = dut_eq;
    end

    assign mismatch    = (state_q == RUN) && (obs_flags != exp_flags);
    assign last_vec    = (vec_q == '1);
    assign start_sweep = start && (state_q != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_vec) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // The vector counter wraps to zero after the last vector, leaving DONE parked at 0/0.
    always_comb begin
        vec_d = vec_q;
        err_d = err_q;
        if (start_sweep) begin
            vec_d = '0;
            err_d = '0;
        end else if (state_q == RUN) begin
            vec_d = vec_q + 1'b1;
            if (mismatch && (err_q != '1)) begin
                err_d = err_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        pass      = (state_q == DONE) && (err_q == '0);
        dut_a     = vec_q[VW-1:WIDTH];
        dut_b     = vec_q[WIDTH-1:0];
        err_count = err_q;
    end

`ifdef CMP_BIST_FIRST_FAIL_EN
    logic             fv_q, fv_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic [2:0]       ff_q, ff_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_q <= 1'b0;
            fa_q <= '0;
            fb_q <= '0;
            ff_q <= '0;
        end else begin
            fv_q <= fv_d;
            fa_q <= fa_d;
            fb_q <= fb_d;
            ff_q <= ff_d;
        end
    end

    always_comb begin
        fv_d = fv_q;
        fa_d = fa_q;
        fb_d = fb_q;
        ff_d = ff_q;
        if (start_sweep) begin
            fv_d = 1'b0;
            fa_d = '0;
            fb_d = '0;
            ff_d = '0;
        end else if (mismatch && !fv_q) begin
            fv_d = 1'b1;
            fa_d = vec_q[VW-1:WIDTH];
            fb_d = vec_q[WIDTH-1:0];
            ff_d = obs_flags;
        end
    end

    assign fail_valid = fv_q;
    assign fail_a     = fa_q;
    assign fail_b     = fb_q;
    assign fail_flags = ff_q;
`endif

endmodule
